// File: rtl/timer_irq_unit_pkg.sv
// Shared constants for the timer interrupt peripheral: bus window, register
// offsets, TCON bit positions and the word-address match helper.
package timer_irq_unit_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h4000_0000;

    localparam logic [31:0] TH_OFF   = 32'd0;
    localparam logic [31:0] TL_OFF   = 32'd4;
    localparam logic [31:0] TCON_OFF = 32'd8;

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int IS_BIT = 2;

    // Byte-lane bits are ignored so sub-word accesses hit the same register.
    function automatic logic word_match(input logic [31:0] addr, input logic [31:0] target);
        return addr[31:2] == target[31:2];
    endfunction

endpackage

// File: rtl/timer_irq_unit_counter.sv
// Reload (TH) and count (TL) registers with increment, reload-on-overflow
// and a combinational overflow pulse for the status logic.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             th_we,
    input  logic             tl_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] th,
    output logic [WIDTH-1:0] tl,
    output logic             ovf
);

    logic [WIDTH-1:0] th_reg, th_next;
    logic [WIDTH-1:0] tl_reg, tl_next;

    assign ovf = en && (tl_reg == {WIDTH{1'b1}});

    always_comb begin
        th_next = th_reg;
        tl_next = tl_reg;
        if (th_we) begin
            th_next = wdata;
        end
        // Reload uses the TH held this cycle; a software TL write wins over both.
        if (ovf) begin
            tl_next = th_reg;
        end else if (en) begin
            tl_next = tl_reg + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (tl_we) begin
            tl_next = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            th_reg <= '0;
            tl_reg <= '0;
        end else begin
            th_reg <= th_next;
            tl_reg <= tl_next;
        end
    end

    assign th = th_reg;
    assign tl = tl_reg;

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer; its registered ILLOP output is the CPU's
// external interrupt request, masked while the fetching PC is in kernel space.
module timer_irq_unit
    import timer_irq_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = timer_irq_unit_pkg::BASE_ADDR,
    parameter int          WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      Address,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    input  logic             in_kernel,
    output logic             ILLOP
);

    localparam logic [31:0] TH_ADDR   = BASE_ADDR + TH_OFF;
    localparam logic [31:0] TL_ADDR   = BASE_ADDR + TL_OFF;
    localparam logic [31:0] TCON_ADDR = BASE_ADDR + TCON_OFF;

    logic             sel_th, sel_tl, sel_tcon;
    logic [WIDTH-1:0] th, tl;
    logic             ovf;
    logic [2:0]       tcon_reg, tcon_next;
    logic             illop_reg, illop_next;

    assign sel_th   = word_match(Address, TH_ADDR);
    assign sel_tl   = word_match(Address, TL_ADDR);
    assign sel_tcon = word_match(Address, TCON_ADDR);

    timer_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .srst  (reset),
        .en    (tcon_reg[EN_BIT]),
        .th_we (MemWrite && sel_th),
        .tl_we (MemWrite && sel_tl),
        .wdata (WriteData),
        .th    (th),
        .tl    (tl),
        .ovf   (ovf)
    );

    always_comb begin
        tcon_next = tcon_reg;
        if (MemWrite && sel_tcon) begin
            tcon_next = WriteData[2:0];
        end
        // Overflow set is applied last so a coincident acknowledge cannot lose it.
        if (ovf && tcon_reg[IE_BIT]) begin
            tcon_next[IS_BIT] = 1'b1;
        end
        illop_next = tcon_next[IS_BIT] & tcon_next[IE_BIT] & ~in_kernel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcon_reg  <= '0;
            illop_reg <= 1'b0;
        end else begin
            tcon_reg  <= tcon_next;
            illop_reg <= illop_next;
        end
    end

    assign ILLOP = illop_reg;

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (sel_th) begin
                ReadData = th;
            end else if (sel_tl) begin
                ReadData = tl;
            end else if (sel_tcon) begin
                ReadData = {{(WIDTH-3){1'b0}}, tcon_reg};
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed bench for timer_irq_unit: reset, reload, acknowledge, masking,
// write precedence and address decode, with hand-computed expectations.
module tb_timer_irq_unit;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        in_kernel = 1'b0;
    logic        ILLOP;

    int checks = 0;
    int errors = 0;

    timer_irq_unit #(
        .BASE_ADDR (BASE),
        .WIDTH     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .in_kernel (in_kernel),
        .ILLOP     (ILLOP)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        Address = a;
        MemRead = 1'b1;
        #1;
        d = ReadData;
        MemRead = 1'b0;
        Address = '0;
        chk(tag, d, exp);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;

        // Build up non-zero state and a pending interrupt, then reset.
        sw(A_TH, 32'h0000_0055);
        sw(A_TL, 32'hFFFF_FFFF);
        sw(A_TC, 32'h0000_0007);
        chk("pre_reset_illop", {31'd0, ILLOP}, 32'd1);
        reset = 1'b1;
        tick();
        chk("reset_illop", {31'd0, ILLOP}, 32'd0);
        rd("reset_th", A_TH, 32'h0);
        rd("reset_tl", A_TL, 32'h0);
        rd("reset_tcon", A_TC, 32'h0);
        tick();
        reset = 1'b0;

        // Reload: TL FE -> FF -> TH, status set at the reload edge.
        sw(A_TH, 32'hFFFF_FFFC);
        sw(A_TL, 32'hFFFF_FFFE);
        sw(A_TC, 32'h0000_0003);
        rd("rl_tl_start", A_TL, 32'hFFFF_FFFE);
        tick();
        rd("rl_tl_ones", A_TL, 32'hFFFF_FFFF);
        chk("rl_illop_before", {31'd0, ILLOP}, 32'd0);
        tick();
        rd("rl_tl_reload", A_TL, 32'hFFFF_FFFC);
        rd("rl_tcon_set", A_TC, 32'h7);
        chk("rl_illop", {31'd0, ILLOP}, 32'd1);

        // Acknowledge without overflow: TL FC -> FD.
        sw(A_TC, 32'h0000_0003);
        rd("ack_tcon", A_TC, 32'h3);
        chk("ack_illop", {31'd0, ILLOP}, 32'd0);
        rd("ack_tl", A_TL, 32'hFFFF_FFFD);
        tick();
        tick();
        rd("ack2_tl_ones", A_TL, 32'hFFFF_FFFF);
        // Acknowledge landing on the overflow edge: the set wins.
        sw(A_TC, 32'h0000_0003);
        rd("ack2_tcon", A_TC, 32'h7);
        chk("ack2_illop", {31'd0, ILLOP}, 32'd1);

        // Masking while status pending.
        in_kernel = 1'b1;
        tick();
        chk("mask_illop", {31'd0, ILLOP}, 32'd0);
        rd("mask_tcon", A_TC, 32'h7);
        in_kernel = 1'b0;
        tick();
        chk("unmask_illop", {31'd0, ILLOP}, 32'd1);
        rd("unmask_tl", A_TL, 32'hFFFF_FFFE);

        // Run without irq enable: overflow sets nothing.
        sw(A_TC, 32'h0000_0001);
        rd("noie_tl_ones", A_TL, 32'hFFFF_FFFF);
        tick();
        rd("noie_tl_reload", A_TL, 32'hFFFF_FFFC);
        rd("noie_tcon", A_TC, 32'h1);
        chk("noie_illop", {31'd0, ILLOP}, 32'd0);

        // TL write on an overflow edge overrides the reload.
        tick();
        tick();
        tick();
        rd("prec_tl_ones", A_TL, 32'hFFFF_FFFF);
        sw(A_TL, 32'h0000_0005);
        rd("prec_tl_write", A_TL, 32'h0000_0005);

        // TH write on an overflow edge: reload takes the old TH.
        sw(A_TL, 32'hFFFF_FFFF);
        sw(A_TH, 32'h0000_0007);
        rd("prec_th_tl", A_TL, 32'hFFFF_FFFC);
        rd("prec_th_th", A_TH, 32'h0000_0007);

        // Stop the timer: TL holds.
        sw(A_TC, 32'h0000_0000);
        tick();
        rd("stop_tl_hold", A_TL, 32'hFFFF_FFFD);

        // Decode.
        sw(BASE + 32'd12, 32'hFFFF_FFFF);
        sw(32'h1000_0004, 32'h0000_1234);
        rd("dec_th", A_TH, 32'h0000_0007);
        rd("dec_tl", A_TL, 32'hFFFF_FFFD);
        rd("dec_tcon", A_TC, 32'h0);
        tick();
        rd("dec_rd_off12", BASE + 32'd12, 32'h0);
        rd("dec_rd_other", 32'h1000_0004, 32'h0);
        rd("dec_rd_plus5", BASE + 32'd5, 32'hFFFF_FFFD);
        sw(BASE + 32'd6, 32'h0000_00AA);
        rd("dec_wr_plus6", A_TL, 32'h0000_00AA);
        Address = A_TL;
        MemRead = 1'b0;
        #1;
        chk("dec_no_memread", ReadData, 32'h0);
        Address = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
